// File: rtl/mux_reg_scan.sv
// Registered N-to-1 channel selector: captures one channel per enabled cycle, picked either
// by an external select (direct mode) or by a round-robin pointer that skips masked channels.
module mux_reg_scan #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic [N_CH-1:0]       ch_en,
  input  logic                  en,
  output logic [WIDTH-1:0]      dout,
  output logic [SEL_W-1:0]      dout_ch,
  output logic                  dout_vld,
  output logic                  err
);

  localparam int               N_PAD   = 1 << SEL_W;
  localparam logic [SEL_W:0]   N_CH_L  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [WIDTH-1:0] r_dout;
  logic [SEL_W-1:0] r_dout_ch;
  logic             r_vld;
  logic             r_err;
  logic [SEL_W-1:0] r_ptr;

  // Channels padded to a power of two so any select value indexes safely.
  logic [WIDTH-1:0] w_ch_data [N_PAD];
  logic [N_PAD-1:0] w_en_pad;

  genvar gi;
  generate
    for (gi = 0; gi < N_PAD; gi++) begin : g_pad
      if (gi < N_CH) begin : g_real
        assign w_ch_data[gi] = din[gi*WIDTH +: WIDTH];
        assign w_en_pad[gi]  = ch_en[gi];
      end else begin : g_fill
        assign w_ch_data[gi] = '0;
        assign w_en_pad[gi]  = 1'b0;
      end
    end
  endgenerate

  logic w_sel_in_range;
  logic w_direct_ok;

  assign w_sel_in_range = ({1'b0, sel} < N_CH_L);
  assign w_direct_ok    = w_sel_in_range & w_en_pad[sel];

  logic [SEL_W:0]   w_cand;
  logic             w_found;
  logic [SEL_W-1:0] w_hit;
  logic [SEL_W-1:0] w_ptr_next;

  // Walk offsets from high to low so the smallest offset from r_ptr wins.
  always_comb begin
    w_cand  = '0;
    w_found = 1'b0;
    w_hit   = r_ptr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_cand = {1'b0, r_ptr} + (SEL_W+1)'(i);
      if (w_cand >= N_CH_L) begin
        w_cand = w_cand - N_CH_L;
      end
      if (w_en_pad[w_cand[SEL_W-1:0]]) begin
        w_found = 1'b1;
        w_hit   = w_cand[SEL_W-1:0];
      end
    end
  end

  assign w_ptr_next = (w_hit == LAST_CH) ? '0 : w_hit + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_dout    <= '0;
      r_dout_ch <= '0;
      r_vld     <= 1'b0;
      r_err     <= 1'b0;
      r_ptr     <= '0;
    end else begin
      r_vld <= 1'b0;
      r_err <= 1'b0;
      if (!mode) begin
        r_ptr <= '0;
      end
      if (en) begin
        if (!mode) begin
          if (!w_sel_in_range) begin
            r_dout    <= '0;
            r_dout_ch <= '0;
            r_err     <= 1'b1;
          end else if (w_direct_ok) begin
            r_dout    <= w_ch_data[sel];
            r_dout_ch <= sel;
            r_vld     <= 1'b1;
          end
        end else if (w_found) begin
          r_dout    <= w_ch_data[w_hit];
          r_dout_ch <= w_hit;
          r_vld     <= 1'b1;
          r_ptr     <= w_ptr_next;
        end
      end
    end
  end

  assign dout     = r_dout;
  assign dout_ch  = r_dout_ch;
  assign dout_vld = r_vld;
  assign err      = r_err;

endmodule

// File: tb/tb_mux_reg_scan.sv
// Bench for mux_reg_scan: directed vector table on a 4-channel instance, hand sequences on a
// 3-channel instance, then randomized traffic on both against a behavioural model.
module tb_mux_reg_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        rst4_b, mode4, en4;
  logic [1:0]  sel4;
  logic [3:0]  chen4;
  logic [31:0] din4;
  logic [7:0]  dout4;
  logic [1:0]  ch4;
  logic        vld4, err4;

  // 3-channel instance (select value 3 is illegal)
  logic        rst3_b, mode3, en3;
  logic [1:0]  sel3;
  logic [2:0]  chen3;
  logic [23:0] din3;
  logic [7:0]  dout3;
  logic [1:0]  ch3;
  logic        vld3, err3;

  mux_reg_scan #(.N_CH(4), .WIDTH(8)) u4 (
    .clk(clk), .rst_b(rst4_b), .din(din4), .sel(sel4), .mode(mode4), .ch_en(chen4),
    .en(en4), .dout(dout4), .dout_ch(ch4), .dout_vld(vld4), .err(err4)
  );

  mux_reg_scan #(.N_CH(3), .WIDTH(8)) u3 (
    .clk(clk), .rst_b(rst3_b), .din(din3), .sel(sel3), .mode(mode3), .ch_en(chen3),
    .en(en3), .dout(dout3), .dout_ch(ch3), .dout_vld(vld3), .err(err3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       rst_b;
    bit       mode;
    bit       en;
    bit [1:0] sel;
    bit [3:0] chen;
    bit [7:0] dout;
    bit [1:0] ch;
    bit       vld;
    bit       err;
  } vec_t;

  function automatic vec_t mk(bit r, bit m, bit e, bit [1:0] s, bit [3:0] c,
                              bit [7:0] d, bit [1:0] ch, bit v, bit er);
    vec_t t;
    t.rst_b = r; t.mode = m; t.en = e; t.sel = s; t.chen = c;
    t.dout = d; t.ch = ch; t.vld = v; t.err = er;
    return t;
  endfunction

  // Behavioural reference: state after one clock edge given the inputs sampled at it.
  typedef struct {
    logic [7:0] dout;
    int         ch;
    bit         vld;
    bit         err;
    int         ptr;
  } model_t;

  function automatic model_t mstep(model_t s, int n, bit rst_b, bit mode, bit en, int sel,
                                   bit [3:0] chen, bit [31:0] din);
    model_t r = s;
    bit     found = 0;
    r.vld = 0;
    r.err = 0;
    if (!rst_b) begin
      r.dout = 0; r.ch = 0; r.ptr = 0;
      return r;
    end
    if (!mode) r.ptr = 0;
    if (en) begin
      if (!mode) begin
        if (sel >= n) begin
          r.dout = 0; r.ch = 0; r.err = 1;
        end else if (chen[sel]) begin
          r.dout = din[sel*8 +: 8]; r.ch = sel; r.vld = 1;
        end
      end else begin
        for (int off = 0; off < n; off++) begin
          int k = (s.ptr + off) % n;
          if (!found && chen[k]) begin
            found = 1;
            r.dout = din[k*8 +: 8]; r.ch = k; r.vld = 1; r.ptr = (k + 1) % n;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic drive3(bit r, bit m, bit e, bit [1:0] s, bit [2:0] c);
    rst3_b = r; mode3 = m; en3 = e; sel3 = s; chen3 = c;
  endtask

  task automatic check3(string name, int idx, bit [7:0] d, bit [1:0] c, bit v, bit er);
    check({name, "_dout"}, idx, 32'(dout3), 32'(d));
    check({name, "_ch"},   idx, 32'(ch3),   32'(c));
    check({name, "_vld"},  idx, 32'(vld3),  32'(v));
    check({name, "_err"},  idx, 32'(err3),  32'(er));
  endtask

  vec_t   vt[23];
  model_t m4, m3;

  initial begin
    din4 = 32'h44332211;
    din3 = 24'h332211;
    rst4_b = 0; mode4 = 1; en4 = 1; sel4 = 0; chen4 = 4'hF;
    drive3(0, 0, 0, 0, 3'b111);

    //          rst mode en sel chen  dout   ch vld err
    vt[0]  = mk(0, 1, 1, 0, 4'hF, 8'h00, 0, 0, 0);
    vt[1]  = mk(0, 1, 1, 0, 4'hF, 8'h00, 0, 0, 0);
    vt[2]  = mk(1, 0, 0, 0, 4'hF, 8'h00, 0, 0, 0);
    vt[3]  = mk(1, 0, 0, 0, 4'hF, 8'h00, 0, 0, 0);
    vt[4]  = mk(1, 0, 1, 0, 4'hF, 8'h11, 0, 1, 0);
    vt[5]  = mk(1, 0, 1, 1, 4'hF, 8'h22, 1, 1, 0);
    vt[6]  = mk(1, 0, 1, 2, 4'hF, 8'h33, 2, 1, 0);
    vt[7]  = mk(1, 0, 1, 3, 4'hF, 8'h44, 3, 1, 0);
    vt[8]  = mk(1, 0, 1, 1, 4'hD, 8'h44, 3, 0, 0);
    vt[9]  = mk(1, 0, 0, 1, 4'hF, 8'h44, 3, 0, 0);
    vt[10] = mk(1, 1, 1, 0, 4'hA, 8'h22, 1, 1, 0);
    vt[11] = mk(1, 1, 1, 0, 4'hA, 8'h44, 3, 1, 0);
    vt[12] = mk(1, 1, 1, 0, 4'hA, 8'h22, 1, 1, 0);
    vt[13] = mk(1, 1, 1, 0, 4'hA, 8'h44, 3, 1, 0);
    vt[14] = mk(1, 1, 1, 0, 4'hA, 8'h22, 1, 1, 0);
    vt[15] = mk(1, 1, 1, 0, 4'h4, 8'h33, 2, 1, 0);
    vt[16] = mk(1, 1, 1, 0, 4'h0, 8'h33, 2, 0, 0);
    vt[17] = mk(1, 1, 1, 0, 4'hF, 8'h44, 3, 1, 0);
    vt[18] = mk(1, 1, 1, 0, 4'hF, 8'h11, 0, 1, 0);
    vt[19] = mk(1, 1, 1, 0, 4'hF, 8'h22, 1, 1, 0);
    vt[20] = mk(1, 0, 1, 3, 4'hF, 8'h44, 3, 1, 0);
    vt[21] = mk(1, 1, 1, 0, 4'hF, 8'h11, 0, 1, 0);
    vt[22] = mk(1, 1, 0, 0, 4'hF, 8'h11, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      rst4_b = vt[i].rst_b; mode4 = vt[i].mode; en4 = vt[i].en;
      sel4 = vt[i].sel; chen4 = vt[i].chen;
      if (i == 2) drive3(1, 0, 0, 0, 3'b111);
      tick();
      check("vec_dout", i, 32'(dout4), 32'(vt[i].dout));
      check("vec_ch",   i, 32'(ch4),   32'(vt[i].ch));
      check("vec_vld",  i, 32'(vld4),  32'(vt[i].vld));
      check("vec_err",  i, 32'(err4),  32'(vt[i].err));
      $display("vec %0d: dout=%0h ch=%0d vld=%0b err=%0b", i, dout4, ch4, vld4, err4);
    end
    en4 = 0;

    // Illegal direct select on the 3-channel instance
    drive3(1, 0, 1, 2, 3'b111); tick(); check3("ill_pre", 0, 8'h33, 2, 1, 0);
    drive3(1, 0, 1, 3, 3'b111); tick(); check3("ill", 0, 8'h00, 0, 0, 1);
    drive3(1, 0, 0, 3, 3'b111); tick(); check3("ill_post", 0, 8'h00, 0, 0, 0);

    // Scan wrap 0,1,2,0 at a non-power-of-two channel count
    for (int i = 0; i < 4; i++) begin
      drive3(1, 1, 1, 0, 3'b111); tick();
      check3("wrap", i, din3[(i%3)*8 +: 8], 2'(i % 3), 1, 0);
      $display("wrap %0d: dout=%0h ch=%0d", i, dout3, ch3);
    end

    // Reset right after channel 1 is captured; scan restarts at channel 0
    drive3(1, 1, 1, 0, 3'b111); tick(); check3("rst_mid_pre", 0, 8'h22, 1, 1, 0);
    drive3(0, 1, 1, 0, 3'b111); tick(); check3("rst_mid", 0, 8'h00, 0, 0, 0);
    drive3(1, 1, 1, 0, 3'b111); tick(); check3("rst_mid_post", 0, 8'h11, 0, 1, 0);

    // Randomized traffic on both instances against the model
    m4 = '{default: 0};
    m3 = '{default: 0};
    for (int c = 0; c < 400; c++) begin
      rst4_b = (c == 0) ? 1'b0 : ($urandom_range(0, 31) != 0);
      mode4  = 1'($urandom_range(0, 3) != 0);
      en4    = 1'($urandom_range(0, 4) != 0);
      sel4   = 2'($urandom);
      chen4  = 4'($urandom);
      din4   = $urandom;
      rst3_b = (c == 0) ? 1'b0 : ($urandom_range(0, 31) != 0);
      mode3  = 1'($urandom_range(0, 2) != 0);
      en3    = 1'($urandom_range(0, 4) != 0);
      sel3   = 2'($urandom);
      chen3  = 3'($urandom);
      din3   = 24'($urandom);
      m4 = mstep(m4, 4, rst4_b, mode4, en4, int'(sel4), chen4, din4);
      m3 = mstep(m3, 3, rst3_b, mode3, en3, int'(sel3), {1'b0, chen3}, {8'h00, din3});
      tick();
      check("rnd4_dout", c, 32'(dout4), 32'(m4.dout));
      check("rnd4_ch",   c, 32'(ch4),   32'(m4.ch));
      check("rnd4_vld",  c, 32'(vld4),  32'(m4.vld));
      check("rnd4_err",  c, 32'(err4),  32'(m4.err));
      check("rnd3_dout", c, 32'(dout3), 32'(m3.dout));
      check("rnd3_ch",   c, 32'(ch3),   32'(m3.ch));
      check("rnd3_vld",  c, 32'(vld3),  32'(m3.vld));
      check("rnd3_err",  c, 32'(err3),  32'(m3.err));
      $display("rnd %0d: u4 ch=%0d vld=%0b err=%0b | u3 ch=%0d vld=%0b err=%0b",
               c, ch4, vld4, err4, ch3, vld3, err3);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
